// File: rtl/psk8_pkg.sv
`default_nettype none
// ============================================================================
// Module  : psk8_pkg
// Purpose : Shared 8PSK definitions: symbol type and the Gray code assigned
//           to each constellation angle (common to the mapper and demapper).
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package psk8_pkg;

  typedef logic [2:0] psk8_sym_t;

  // Gray codes by angle; adjacent points differ in exactly one bit.
  localparam psk8_sym_t SYM_0   = 3'b000;
  localparam psk8_sym_t SYM_45  = 3'b001;
  localparam psk8_sym_t SYM_90  = 3'b011;
  localparam psk8_sym_t SYM_135 = 3'b010;
  localparam psk8_sym_t SYM_180 = 3'b110;
  localparam psk8_sym_t SYM_225 = 3'b111;
  localparam psk8_sym_t SYM_270 = 3'b101;
  localparam psk8_sym_t SYM_315 = 3'b100;

endpackage : psk8_pkg
`default_nettype wire

// File: rtl/psk8_sector_decide.sv
`default_nettype none
// ============================================================================
// Module  : psk8_sector_decide
// Purpose : Combinational hard decision of the 8PSK sector from the folded
//           sample (magnitudes plus sign bits). The +/-22.5 degree sector
//           edges are tested as |Q|/|I| <= TAN_NUM/TAN_DEN, cross-multiplied
//           so no division is needed.
// Ports   : i_ai  [IN_W] |I| (unsigned)     i_si  I is negative
//           i_aq  [IN_W] |Q| (unsigned)     i_sq  Q is negative
//           o_sym [3]    Gray-coded decided symbol
// Revision: 1.0 - initial release
// ============================================================================
module psk8_sector_decide
  import psk8_pkg::*;
#(
  parameter int IN_W    = 4,
  parameter int TAN_NUM = 5,
  parameter int TAN_DEN = 12
) (
  input  logic [IN_W-1:0] i_ai,
  input  logic [IN_W-1:0] i_aq,
  input  logic            i_si,
  input  logic            i_sq,
  output psk8_sym_t       o_sym
);

  // Four extra bits hold a magnitude times a ratio term below 16.
  localparam int PW = IN_W + 4;

  logic [PW-1:0] w_ai_num;
  logic [PW-1:0] w_aq_num;
  logic [PW-1:0] w_ai_den;
  logic [PW-1:0] w_aq_den;
  logic          w_near_i_axis;
  logic          w_near_q_axis;

  assign w_ai_num = PW'(i_ai) * PW'(TAN_NUM);
  assign w_aq_num = PW'(i_aq) * PW'(TAN_NUM);
  assign w_ai_den = PW'(i_ai) * PW'(TAN_DEN);
  assign w_aq_den = PW'(i_aq) * PW'(TAN_DEN);

  // Ties on a sector edge resolve toward the axis; the I axis wins when both
  // hold, which only happens for the origin.
  assign w_near_i_axis = (w_aq_den <= w_ai_num);
  assign w_near_q_axis = (w_ai_den <= w_aq_num);

  always_comb begin
    o_sym = SYM_0;
    if (w_near_i_axis) begin
      o_sym = i_si ? SYM_180 : SYM_0;
    end else if (w_near_q_axis) begin
      o_sym = i_sq ? SYM_270 : SYM_90;
    end else begin
      case ({i_si, i_sq})
        2'b00:   o_sym = SYM_45;
        2'b10:   o_sym = SYM_135;
        2'b11:   o_sym = SYM_225;
        default: o_sym = SYM_315;
      endcase
    end
  end

endmodule : psk8_sector_decide
`default_nettype wire

// File: rtl/psk8_demapper.sv
`default_nettype none
// ============================================================================
// Module  : psk8_demapper
// Purpose : Hard-decision 8PSK demapper with a 2-stage valid/ready pipeline.
//           Stage 1 folds the sample to magnitudes and signs, stage 2
//           registers the Gray-coded decision and a low-magnitude erasure
//           flag. Delivered-symbol and erasure counters are also kept.
// Ports   : clk, rst (async, active-high)
//           in_valid/in_ready, i_in[IN_W], q_in[IN_W]   sample input
//           out_valid/out_ready, sym_out[3], erase_out   symbol output
//           cnt_clr                                      clear both counters
//           sym_cnt[CNT_W]   symbols delivered, wraps
//           erase_cnt[CNT_W] erased symbols delivered, saturates
// Revision: 1.0 - initial release
// ============================================================================
module psk8_demapper
  import psk8_pkg::*;
#(
  parameter int IN_W     = 4,
  parameter int TAN_NUM  = 5,
  parameter int TAN_DEN  = 12,
  parameter int ERASE_TH = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  i_in,
  input  logic [IN_W-1:0]  q_in,
  output logic             out_valid,
  input  logic             out_ready,
  output psk8_sym_t        sym_out,
  output logic             erase_out,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] sym_cnt,
  output logic [CNT_W-1:0] erase_cnt
);

  // One spare bit above the magnitude sum so a threshold beyond the largest
  // possible sum still compares correctly.
  localparam logic [IN_W+1:0] c_erase_th = (IN_W + 2)'(ERASE_TH);

  // ---------------------------------------------------------------- handshake
  logic w_adv;
  logic w_fire;

  assign w_adv    = !out_valid || out_ready;
  assign w_fire   = out_valid && out_ready;
  assign in_ready = w_adv;

  // ---------------------------------------------------------------- stage 1
  logic            w_si;
  logic            w_sq;
  logic [IN_W-1:0] w_ai;
  logic [IN_W-1:0] w_aq;
  logic [IN_W:0]   w_mag;

  assign w_si  = i_in[IN_W-1];
  assign w_sq  = q_in[IN_W-1];
  // Unsigned result: the most negative input maps to 2^(IN_W-1) without wrap.
  assign w_ai  = w_si ? (~i_in + IN_W'(1)) : i_in;
  assign w_aq  = w_sq ? (~q_in + IN_W'(1)) : q_in;
  assign w_mag = {1'b0, w_ai} + {1'b0, w_aq};

  logic            r_s1_valid;
  logic            r_si;
  logic            r_sq;
  logic [IN_W-1:0] r_ai;
  logic [IN_W-1:0] r_aq;
  logic [IN_W:0]   r_mag;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_si       <= 1'b0;
      r_sq       <= 1'b0;
      r_ai       <= '0;
      r_aq       <= '0;
      r_mag      <= '0;
    end else if (w_adv) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_si  <= w_si;
        r_sq  <= w_sq;
        r_ai  <= w_ai;
        r_aq  <= w_aq;
        r_mag <= w_mag;
      end
    end
  end

  // ---------------------------------------------------------------- stage 2
  psk8_sym_t w_sym;
  logic      w_erase;

  psk8_sector_decide #(
    .IN_W    (IN_W),
    .TAN_NUM (TAN_NUM),
    .TAN_DEN (TAN_DEN)
  ) u_decide (
    .i_ai  (r_ai),
    .i_aq  (r_aq),
    .i_si  (r_si),
    .i_sq  (r_sq),
    .o_sym (w_sym)
  );

  assign w_erase = ({1'b0, r_mag} < c_erase_th);

  logic      r_out_valid;
  psk8_sym_t r_sym;
  logic      r_erase;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_sym       <= SYM_0;
      r_erase     <= 1'b0;
    end else if (w_adv) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_sym   <= w_sym;
        r_erase <= w_erase;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign sym_out   = r_sym;
  assign erase_out = r_erase;

  // ---------------------------------------------------------------- counters
  logic [CNT_W-1:0] r_sym_cnt;
  logic [CNT_W-1:0] r_erase_cnt;

  // Clear takes priority over an increment in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sym_cnt   <= '0;
      r_erase_cnt <= '0;
    end else if (cnt_clr) begin
      r_sym_cnt   <= '0;
      r_erase_cnt <= '0;
    end else if (w_fire) begin
      r_sym_cnt <= r_sym_cnt + CNT_W'(1);
      if (r_erase && (r_erase_cnt != '1)) begin
        r_erase_cnt <= r_erase_cnt + CNT_W'(1);
      end
    end
  end

  assign sym_cnt   = r_sym_cnt;
  assign erase_cnt = r_erase_cnt;

endmodule : psk8_demapper
`default_nettype wire

// File: tb/tb_psk8_demapper.sv
`default_nettype none
// ============================================================================
// Module  : tb_psk8_demapper
// Purpose : Self-checking bench for psk8_demapper. Two instances share all
//           inputs (erasure threshold 1 and 3); accepted samples are turned
//           into expected symbols by an angle-based reference model and
//           compared in order as symbols are delivered.
// Revision: 1.0 - initial release
// ============================================================================
module tb_psk8_demapper;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_ready3;
  logic [3:0]  i_in;
  logic [3:0]  q_in;
  logic        out_valid;
  logic        out_valid3;
  logic        out_ready;
  logic [2:0]  sym_out;
  logic [2:0]  sym3;
  logic        erase_out;
  logic        erase3;
  logic        cnt_clr;
  logic [15:0] sym_cnt;
  logic [15:0] erase_cnt;
  logic [15:0] sym_cnt3;
  logic [15:0] erase_cnt3;

  psk8_demapper #(.ERASE_TH(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .i_in(i_in), .q_in(q_in), .out_valid(out_valid), .out_ready(out_ready),
    .sym_out(sym_out), .erase_out(erase_out), .cnt_clr(cnt_clr),
    .sym_cnt(sym_cnt), .erase_cnt(erase_cnt)
  );

  psk8_demapper #(.ERASE_TH(3)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready3),
    .i_in(i_in), .q_in(q_in), .out_valid(out_valid3), .out_ready(out_ready),
    .sym_out(sym3), .erase_out(erase3), .cnt_clr(cnt_clr),
    .sym_cnt(sym_cnt3), .erase_cnt(erase_cnt3)
  );

  always #5 clk = ~clk;

  // ------------------------------------------------------------ checking
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ------------------------------------------------------------ reference model
  typedef struct packed {
    logic [2:0] sym;
    logic       er;
    logic       er3;
  } exp_t;

  // Gray code of the point at angle 45*k degrees.
  logic [2:0] gray_by_octant [8] = '{3'b000, 3'b001, 3'b011, 3'b010,
                                     3'b110, 3'b111, 3'b101, 3'b100};

  function automatic exp_t model(input int i, input int q);
    exp_t e;
    int ai, aq, k;
    ai = (i < 0) ? -i : i;
    aq = (q < 0) ? -q : q;
    // Sector edges at 22.5 degrees off each axis, tan approximated as 5/12.
    if (aq * 12 <= ai * 5)      k = (i < 0) ? 4 : 0;
    else if (ai * 12 <= aq * 5) k = (q < 0) ? 6 : 2;
    else if (i > 0 && q > 0)    k = 1;
    else if (i < 0 && q > 0)    k = 3;
    else if (i < 0 && q < 0)    k = 5;
    else                        k = 7;
    e.sym = gray_by_octant[k];
    e.er  = (ai + aq) < 1;
    e.er3 = (ai + aq) < 3;
    return e;
  endfunction

  // ------------------------------------------------------------ scoreboard
  exp_t        exp_q[$];
  exp_t        e_pop;
  logic [15:0] m_sym_cnt;
  logic [15:0] m_erase_cnt;
  bit          has_hold;
  logic [3:0]  hold_val;

  // Inputs change only just after posedge, so values seen at negedge are
  // exactly what the next posedge will act upon.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      m_sym_cnt   = '0;
      m_erase_cnt = '0;
      has_hold    = 1'b0;
    end else begin
      if (has_hold) begin
        check("stall_valid_held", out_valid, 1);
        check("stall_data_held", {sym_out, erase_out}, hold_val);
      end
      check("sym_cnt", sym_cnt, m_sym_cnt);
      check("erase_cnt", erase_cnt, m_erase_cnt);
      if (out_valid && !out_ready) check("in_ready_stall", in_ready, 0);
      if (out_ready) check("in_ready_free", in_ready, 1);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("out_valid_unexpected", out_valid, 0);
        end else begin
          e_pop = exp_q.pop_front();
          check("sym", sym_out, e_pop.sym);
          check("erase", erase_out, e_pop.er);
          check("th3_valid", out_valid3, 1);
          check("th3_sym", sym3, e_pop.sym);
          check("th3_erase", erase3, e_pop.er3);
          m_sym_cnt = m_sym_cnt + 16'd1;
          if (e_pop.er && m_erase_cnt != 16'hFFFF) m_erase_cnt = m_erase_cnt + 16'd1;
        end
      end
      if (cnt_clr) begin
        m_sym_cnt   = '0;
        m_erase_cnt = '0;
      end
      has_hold = out_valid && !out_ready;
      hold_val = {sym_out, erase_out};
      if (in_valid && in_ready) exp_q.push_back(model(int'($signed(i_in)), int'($signed(q_in))));
    end
  end

  // ------------------------------------------------------------ out_ready driver
  int ready_mode = 0;  // 0: always ready, 1: random, 2: stalled

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  // ------------------------------------------------------------ stimulus tasks
  // Called just after a posedge; returns just after the accepting posedge.
  task automatic send(input int i, input int q);
    bit ok;
    ok       = 1'b0;
    in_valid = 1'b1;
    i_in     = 4'(i);
    q_in     = 4'(q);
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("accept_timeout", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_rand();
    send(int'($urandom_range(0, 15)) - 8, int'($urandom_range(0, 15)) - 8);
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) check("drain_timeout", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clr();
    cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    cnt_clr = 1'b0;
  endtask

  int di[17] = '{2, 1, -1, -2, -1, 0, 1, 0, 5, 5, 2, -6, -8, -8, 0, 1, 2};
  int dq[17] = '{0, 1, 1, 0, -1, -2, -1, 2, 2, 3, 5, -2, -8, 0, 0, 1, 1};

  // ------------------------------------------------------------ main sequence
  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    i_in     = '0;
    q_in     = '0;
    cnt_clr  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_sym", sym_out, 0);
    check("rst_erase", erase_out, 0);
    check("rst_sym_cnt", sym_cnt, 0);
    check("rst_erase_cnt", erase_cnt, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("in_ready_after_rst", in_ready, 1);

    // Latency: accepted at edge k, visible after edge k+1.
    send(2, 0);
    check("latency_k", out_valid, 0);
    @(posedge clk);
    #1;
    check("latency_k1", out_valid, 1);
    check("latency_sym", sym_out, 3'b000);
    drain();

    // Constellation points, boundaries and erasures back-to-back.
    for (int n = 0; n < 17; n++) send(di[n], dq[n]);
    drain();

    // Backpressure mid-stream.
    pulse_clr();
    fork
      begin
        for (int n = 0; n < 6; n++) send_rand();
      end
      begin
        repeat (2) @(posedge clk);
        #1;
        ready_mode = 2;
        repeat (3) @(posedge clk);
        #1;
        ready_mode = 0;
      end
    join
    drain();
    check("bp_sym_cnt", sym_cnt, 6);

    // Randomized traffic with random backpressure and input gaps.
    ready_mode = 1;
    for (int n = 0; n < 400; n++) begin
      send_rand();
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    ready_mode = 0;
    drain();

    // Clear coinciding with a delivery.
    fork
      begin
        for (int n = 0; n < 4; n++) send_rand();
      end
      begin
        for (int n = 0; n < 20; n++) begin
          @(posedge clk);
          #1;
          if (out_valid) break;
        end
        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        check("clr_sym_cnt", sym_cnt, 0);
        check("clr_erase_cnt", erase_cnt, 0);
      end
    join
    drain();

    // Saturation of erase_cnt and wrap of sym_cnt.
    pulse_clr();
    for (int n = 0; n < 65535; n++) send(0, 0);
    drain();
    check("sat_sym_cnt", sym_cnt, 16'hFFFF);
    check("sat_erase_cnt", erase_cnt, 16'hFFFF);
    check("sat_erase_cnt_th3", erase_cnt3, 16'hFFFF);
    send(0, 0);
    drain();
    check("wrap_sym_cnt", sym_cnt, 16'h0000);
    check("sat_hold_erase_cnt", erase_cnt, 16'hFFFF);

    // Asynchronous reset with two samples in flight.
    send(1, 1);
    send(-2, 0);
    #2;
    rst = 1'b1;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_out_valid_th3", out_valid3, 0);
    check("arst_sym_cnt", sym_cnt, 0);
    check("arst_erase_cnt", erase_cnt, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("no_stale_after_rst", out_valid, 0);
    send(0, -2);
    send(-1, -1);
    drain();
    check("post_rst_sym_cnt", sym_cnt, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule : tb_psk8_demapper
`default_nettype wire
